spi_initiator: RTL and testbench



---
 rtl/spi_initiator.sv | 176 +++++++++++++++++
 tb/tb_spi_initiator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_initiator.sv
// SPI initiator, mode 0, MSB first, fixed-width frames.
// Programmable sclk half-period; chip select can be held across frames.
module spi_initiator #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              hold_cs,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        TRAIL,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              hold_q, hold_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;

    // End of a half-period: counter compares against the latched divider,
    // so H = 2^DIV_W is reachable without widening the counter.
    assign tick = (cnt_q == div_q);

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        hold_d  = hold_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = tx_data;
                    div_d   = div;
                    hold_d  = hold_cs;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_data[DATA_W-1];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (!sclk_q) begin
                        sh_d = {sh_q[DATA_W-2:0], miso};
                    end else if (edge_q == EW'(2 * DATA_W - 1)) begin
                        state_d = TRAIL;
                    end else begin
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[DATA_W-2];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRAIL: begin
                if (tick) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    rx_d   = sh_q;
                    if (hold_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            hold_q  <= 1'b0;
            edge_q  <= '0;
            tx_q    <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_initiator.sv
// Scoreboard bench for spi_initiator: stimulus pushes expected frames,
// a negedge monitor checks timing, serial bits and received data.
module tb_spi_initiator;

    localparam int DW     = 8;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] div;
    logic       start;
    logic [7:0] tx_data;
    logic       hold_cs;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;

    spi_initiator #(.DATA_W(DW), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .div(div), .start(start),
        .tx_data(tx_data), .hold_cs(hold_cs), .busy(busy),
        .done(done), .rx_data(rx_data), .cs_n(cs_n), .sclk(sclk),
        .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         h;
        bit         hold;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Responder model: mode 0, next bit presented on sclk falling edge.
    bit         loopback;
    logic [7:0] slave_word;
    logic [2:0] sidx;
    logic       slave_bit;
    assign slave_bit = slave_word[3'd7 - sidx];
    assign miso = loopback ? mosi : slave_bit;
    always @(negedge cs_n) sidx = 3'd0;
    always @(negedge sclk) if (!cs_n) sidx = sidx + 3'd1;

    function automatic void chk(input string nm, input int act, input int e);
        checks++;
        if (act != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, e, $time);
        end
    endfunction

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Monitor state.
    bit         infr, ingap, held_low, cs_hi_seen;
    int         flen, hi, lo, pulses, gap, gap_h, cur_h;
    bit         cs_bad;
    logic [7:0] seen;
    logic       prev_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            infr = 0; ingap = 0; held_low = 0; cs_hi_seen = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                infr = 1; flen = 0; hi = 0; lo = 0; pulses = 0;
                seen = 8'h00; cs_bad = 0;
                cur_h = (exp_q.size() > 0) ? exp_q[0].h : 0;
            end
            if (ingap) begin
                if (busy) gap++;
                else begin
                    chk("gap_len", gap, gap_h);
                    ingap = 0;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_len", flen, (2 * DW + 2) * e.h);
                    chk("cs_low_in_frame", int'(cs_bad), 0);
                    chk("sclk_pulses", pulses, DW);
                    chk("mosi_bits", int'(seen), int'(e.tx));
                    chk("rx_data", int'(rx_data), int'(e.rx));
                    chk("cs_n_at_done", int'(cs_n), int'(!e.hold));
                    chk("busy_at_done", int'(busy), int'(!e.hold));
                    if (held_low) chk("cs_held_low", int'(cs_hi_seen), 0);
                    held_low = e.hold;
                    cs_hi_seen = 0;
                    if (!e.hold) begin
                        ingap = 1; gap = 1; gap_h = e.h;
                    end
                end
                infr = 0;
            end else begin
                if (held_low && cs_n) cs_hi_seen = 1;
                if (infr) begin
                    flen++;
                    if (cs_n) cs_bad = 1;
                    if (sclk) begin
                        if (hi == 0 && pulses > 0) chk("sclk_low", lo, cur_h);
                        if (hi == 0) seen = {seen[6:0], mosi};
                        hi++;
                        lo = 0;
                    end else begin
                        if (hi > 0) begin
                            chk("sclk_high", hi, cur_h);
                            pulses++;
                            hi = 0;
                        end
                        lo++;
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= BUDGET) begin
            chk("idle_timeout", 1, 0);
            finish_run();
        end
    endtask

    task automatic send(input logic [7:0] tx, input logic [7:0] d,
                        input bit hold, input bit loop,
                        input logic [7:0] sw);
        exp_t e;
        wait_idle();
        loopback   = loop;
        slave_word = sw;
        start      = 1'b1;
        tx_data    = tx;
        div        = d;
        hold_cs    = hold;
        e.rx   = loop ? tx : sw;
        e.tx   = tx;
        e.h    = int'(d) + 1;
        e.hold = hold;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start   = 1'b0;
        tx_data = 8'($urandom);
        div     = 8'($urandom);
        hold_cs = 1'($urandom);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cs_n"}, int'(cs_n), 1);
        chk({tag, "_sclk"}, int'(sclk), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rx"}, int'(rx_data), 0);
        chk({tag, "_mosi"}, int'(mosi), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; div = 8'd0; tx_data = 8'd0;
        hold_cs = 1'b0; loopback = 1'b1; slave_word = 8'h00; sidx = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fastest rate loopback.
        send(8'hA5, 8'd0, 1'b0, 1'b1, 8'h00);
        // Slow rate against responder model.
        send(8'h96, 8'd3, 1'b0, 1'b0, 8'h3C);
        // Held chip select burst.
        send(8'h12, 8'd1, 1'b1, 1'b1, 8'h00);
        send(8'h34, 8'd1, 1'b0, 1'b1, 8'h00);

        // Starts while busy must be ignored.
        send(8'h42, 8'd1, 1'b0, 1'b1, 8'h00);
        @(posedge clk); #1;
        start = 1'b1; tx_data = 8'hFF; div = 8'd0; hold_cs = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1; tx_data = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;

        // Reset during the 4th bit.
        send(8'hC3, 8'd2, 1'b0, 1'b1, 8'h00);
        repeat (23) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_state("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h5A, 8'd0, 1'b0, 1'b1, 8'h00);

        // Divider changes mid-frame, next frame uses the new value.
        send(8'h69, 8'd1, 1'b0, 1'b1, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        div = 8'd7;
        send(8'hB4, 8'd7, 1'b0, 1'b0, 8'hE1);

        // Largest divider: H = 256.
        send(8'h81, 8'hFF, 1'b0, 1'b1, 8'h00);

        // Randomized frames.
        for (int i = 0; i < 14; i++) begin
            send(8'($urandom), 8'($urandom_range(0, 3)),
                 (i == 13) ? 1'b0 : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end

        wait_idle();
        repeat (40) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        finish_run();
    end

endmodule
